// File: rtl/pulse_sched.sv
`default_nettype none
// ============================================================================
// Module   : pulse_sched
// Purpose  : Round-robin scheduler sharing one pulse generator among NREQ
//            requesters. Each granted requester receives a burst of n pulses
//            (n = 0 is treated as 1). The generator runs in periodic mode for
//            the first n-1 pulses and is re-armed in single mode for the last
//            one, so it stops by itself. A watchdog aborts a stalled service.
// Ports    : clk, rst       - clock, synchronous active-high reset
//            req_i          - level request per requester
//            req_cnt_i      - packed pulse counts, slice i for requester i
//            grant_o        - one-hot grant, held for the whole service
//            done_o         - one-cycle completion strobe
//            done_err_o     - high with done_o when aborted by the watchdog
//            busy_o         - high whenever the scheduler is not idle
//            gen_init_o     - generator init
//            gen_per_o      - generator periodic-mode select
//            gen_pulse_i    - generator pulse output
// Revision : 1.0 - initial release
// ============================================================================
module pulse_sched #(
    parameter int NREQ    = 4,
    parameter int CNT_W   = 4,
    parameter int TIMEOUT = 63
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_i,
    input  logic [NREQ*CNT_W-1:0]   req_cnt_i,
    output logic [NREQ-1:0]         grant_o,
    output logic [NREQ-1:0]         done_o,
    output logic                    done_err_o,
    output logic                    busy_o,
    output logic                    gen_init_o,
    output logic                    gen_per_o,
    input  logic                    gen_pulse_i
);

    localparam int C_IDX_W = $clog2(NREQ);
    localparam int C_WD_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARM  = 3'd1,
        S_RUN  = 3'd2,
        S_LAST = 3'd3,
        S_TAIL = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [C_IDX_W-1:0]   ptr_q, ptr_d;
    logic [C_IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]     n_q, n_d;
    logic [CNT_W-1:0]     k_q, k_d;
    logic [C_WD_W-1:0]    wd_q, wd_d;
    logic                 err_q, err_d;
    logic                 pulse_q;

    logic                 w_rise;
    logic                 w_fall;
    logic                 w_found;
    logic [C_IDX_W-1:0]   w_sel;
    logic [C_IDX_W:0]     w_j;
    logic [CNT_W-1:0]     w_cnt;
    logic [C_WD_W-1:0]    w_wd_inc;
    logic                 w_wd_expire;
    logic [NREQ-1:0]      w_onehot;

    assign w_rise = gen_pulse_i & ~pulse_q;
    assign w_fall = ~gen_pulse_i & pulse_q;

    // Round-robin search: first asserted request at or after the pointer,
    // wrapping modulo NREQ (NREQ need not be a power of two).
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_j     = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_j = {1'b0, ptr_q} + (C_IDX_W+1)'(i);
            if (w_j >= (C_IDX_W+1)'(NREQ)) begin
                w_j = w_j - (C_IDX_W+1)'(NREQ);
            end
            if (!w_found && req_i[w_j[C_IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_j[C_IDX_W-1:0];
            end
        end
    end

    assign w_cnt       = req_cnt_i[int'(w_sel)*CNT_W +: CNT_W];
    assign w_wd_inc    = wd_q + 1'b1;
    assign w_wd_expire = (w_wd_inc == C_WD_W'(TIMEOUT));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        n_d     = n_q;
        k_d     = k_q;
        err_d   = err_q;
        // Watchdog reloads on every state entry; only RUN/TAIL let it count.
        wd_d    = '0;
        case (state_q)
            S_IDLE: begin
                err_d = 1'b0;
                if (w_found) begin
                    idx_d   = w_sel;
                    ptr_d   = (w_sel == C_IDX_W'(NREQ-1)) ? '0 : w_sel + 1'b1;
                    n_d     = (w_cnt == '0) ? CNT_W'(1) : w_cnt;
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                k_d     = '0;
                state_d = S_RUN;
            end
            S_RUN, S_TAIL: begin
                if (w_rise) begin
                    k_d = k_q + 1'b1;
                end
                if (w_rise || w_fall) begin
                    wd_d = '0;
                end else if (w_wd_expire) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else begin
                    wd_d = w_wd_inc;
                end
                // Rise and fall never coincide, so on a fall k_q already
                // includes the pulse that is ending.
                if (w_fall) begin
                    if (state_q == S_TAIL) begin
                        if (k_q == n_q) begin
                            state_d = S_FIN;
                        end
                    end else if (n_q == CNT_W'(1)) begin
                        if (k_q == CNT_W'(1)) begin
                            state_d = S_FIN;
                        end
                    end else if (k_q == n_q - 1'b1) begin
                        state_d = S_LAST;
                    end
                end
            end
            S_LAST: begin
                state_d = S_TAIL;
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            n_q     <= '0;
            k_q     <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            k_q     <= k_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
            pulse_q <= gen_pulse_i;
        end
    end

    // Outputs decode from registered state only. Grant is already low in FIN.
    assign w_onehot = NREQ'(1) << idx_q;

    always_comb begin
        grant_o    = '0;
        done_o     = '0;
        done_err_o = 1'b0;
        busy_o     = (state_q != S_IDLE);
        gen_init_o = (state_q == S_ARM) || (state_q == S_LAST);
        gen_per_o  = (state_q == S_ARM) && (n_q > CNT_W'(1));
        case (state_q)
            S_ARM, S_RUN, S_LAST, S_TAIL: grant_o = w_onehot;
            S_FIN: begin
                done_o     = w_onehot;
                done_err_o = err_q;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_pulse_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulse_sched
// Purpose  : Self-checking bench for pulse_sched with a behavioural pulse
//            generator and a round-robin reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_sched;

    localparam int NREQ    = 4;
    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 63;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*CNT_W-1:0] req_cnt = '0;
    logic [NREQ-1:0]       grant_o;
    logic [NREQ-1:0]       done_o;
    logic                  done_err_o;
    logic                  busy_o;
    logic                  gen_init_o;
    logic                  gen_per_o;
    logic                  gen_pulse;

    pulse_sched #(.NREQ(NREQ), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req),
        .req_cnt_i  (req_cnt),
        .grant_o    (grant_o),
        .done_o     (done_o),
        .done_err_o (done_err_o),
        .busy_o     (busy_o),
        .gen_init_o (gen_init_o),
        .gen_per_o  (gen_per_o),
        .gen_pulse_i(gen_pulse)
    );

    always #5 clk = ~clk;

    // Generator model: first pulse rises 10 cycles after init, high 5 cycles,
    // period 40 in periodic mode, a single pulse otherwise.
    logic gen_en = 1'b1;
    logic g_act  = 1'b0;
    logic g_per  = 1'b0;
    logic g_out  = 1'b0;
    int   g_cnt  = 0;

    function automatic logic pulse_at(input int c, input logic per);
        if (c < 10) return 1'b0;
        if (per) return (((c - 10) % 40) < 5);
        return (c < 15);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            g_act <= 1'b0;
            g_cnt <= 0;
            g_out <= 1'b0;
        end else if (gen_init_o) begin
            g_act <= 1'b1;
            g_per <= gen_per_o;
            g_cnt <= 0;
            g_out <= 1'b0;
        end else if (g_act) begin
            g_cnt <= g_cnt + 1;
            g_out <= pulse_at(g_cnt + 1, g_per);
            if (!g_per && (g_cnt + 1 > 14)) g_act <= 1'b0;
        end
    end

    assign gen_pulse = gen_en & g_out;

    int n_checks = 0;
    int n_fail   = 0;
    bit scramble = 1'b0;

    // Observations of one service, filled by observe().
    bit              obs_timeout;
    logic [NREQ-1:0] obs_grant, obs_done, obs_grant_at_done;
    logic            obs_derr, obs_per0, obs_per1, obs_stable, obs_busy_after;
    int              obs_pulses, obs_falls, obs_inits, obs_falls_at_init2;
    int              obs_fall_to_done, obs_run_to_done;

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        req    = '0;
        gen_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Waits for a grant, follows the service until done, then samples busy
    // one cycle later. All sampling on falling edges.
    task automatic observe(input int budget);
        int   t;
        int   last_fall;
        int   init_t;
        logic prev;
        obs_timeout = 1'b0; obs_pulses = 0; obs_falls = 0; obs_inits = 0;
        obs_falls_at_init2 = -1; obs_per0 = 1'bx; obs_per1 = 1'bx;
        obs_done = '0; obs_derr = 1'b0; obs_stable = 1'b1;
        obs_fall_to_done = -1; obs_run_to_done = -1; obs_busy_after = 1'bx;
        t = 0; last_fall = -1000; init_t = 0;
        while (grant_o == '0 && t < budget) begin
            @(negedge clk); t++;
        end
        if (grant_o == '0) begin
            obs_timeout = 1'b1;
            return;
        end
        obs_grant = grant_o;
        if (scramble) begin
            req     = NREQ'($urandom);
            req_cnt = (NREQ*CNT_W)'($urandom);
        end
        prev = gen_pulse;
        while (done_o == '0 && t < budget) begin
            if (grant_o !== obs_grant) obs_stable = 1'b0;
            if (gen_init_o) begin
                if (obs_inits == 0) begin
                    obs_per0 = gen_per_o; init_t = t;
                end else begin
                    obs_per1 = gen_per_o; obs_falls_at_init2 = obs_falls;
                end
                obs_inits++;
            end
            if (gen_pulse && !prev) obs_pulses++;
            if (!gen_pulse && prev) begin obs_falls++; last_fall = t; end
            prev = gen_pulse;
            @(negedge clk); t++;
        end
        if (done_o == '0) begin
            obs_timeout = 1'b1;
            return;
        end
        obs_done          = done_o;
        obs_derr          = done_err_o;
        obs_grant_at_done = grant_o;
        obs_fall_to_done  = t - last_fall;
        obs_run_to_done   = t - (init_t + 1);
        @(negedge clk);
        obs_busy_after = busy_o;
    endtask

    task automatic test_reset();
        logic [2*NREQ+3:0] outs;
        rst = 1'b1;
        req = '1;
        for (int i = 0; i < NREQ; i++) req_cnt[i*CNT_W +: CNT_W] = CNT_W'(1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            outs = {grant_o, done_o, done_err_o, busy_o, gen_init_o, gen_per_o};
            n_checks++;
            if (outs !== '0) begin
                n_fail++; $display("FAIL reset_outputs: got %b required 0", outs);
            end
        end
        rst = 1'b0;
        observe(500);
        req = '0;
        n_checks++;
        if (obs_timeout || obs_grant !== 4'b0001) begin
            n_fail++; $display("FAIL reset_first_grant: got %b required 0001 (timeout=%0d)", obs_grant, obs_timeout);
        end
    endtask

    task automatic test_single();
        do_reset();
        req_cnt = '0;
        req_cnt[1*CNT_W +: CNT_W] = CNT_W'(1);
        req = 4'b0010;
        @(negedge clk);
        n_checks++;
        if ({grant_o, busy_o, gen_init_o} !== {4'b0010, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL single_latency: grant=%b busy=%b init=%b required 0010 1 1", grant_o, busy_o, gen_init_o);
        end
        observe(500);
        req = '0;
        n_checks++;
        if (obs_timeout) begin n_fail++; $display("FAIL single_timeout: service did not complete"); end
        n_checks++;
        if (obs_inits !== 1 || obs_per0 !== 1'b0) begin
            n_fail++; $display("FAIL single_init: inits=%0d per=%b required 1 0", obs_inits, obs_per0);
        end
        n_checks++;
        if (obs_pulses !== 1) begin n_fail++; $display("FAIL single_pulses: got %0d required 1", obs_pulses); end
        n_checks++;
        if (obs_done !== 4'b0010 || obs_derr !== 1'b0) begin
            n_fail++; $display("FAIL single_done: done=%b err=%b required 0010 0", obs_done, obs_derr);
        end
        n_checks++;
        if (obs_fall_to_done !== 1) begin
            n_fail++; $display("FAIL single_done_latency: got %0d required 1", obs_fall_to_done);
        end
        n_checks++;
        if (obs_grant_at_done !== '0 || obs_busy_after !== 1'b0) begin
            n_fail++; $display("FAIL single_release: grant=%b busy_after=%b required 0000 0", obs_grant_at_done, obs_busy_after);
        end
    endtask

    task automatic test_burst();
        int   extra;
        logic prev;
        do_reset();
        req_cnt = '0;
        req_cnt[2*CNT_W +: CNT_W] = CNT_W'(3);
        req = 4'b0100;
        observe(800);
        req = '0;
        n_checks++;
        if (obs_timeout || obs_done !== 4'b0100 || obs_derr !== 1'b0) begin
            n_fail++; $display("FAIL burst_done: done=%b err=%b timeout=%0d required 0100 0 0", obs_done, obs_derr, obs_timeout);
        end
        n_checks++;
        if (obs_inits !== 2 || obs_per0 !== 1'b1 || obs_per1 !== 1'b0) begin
            n_fail++; $display("FAIL burst_inits: inits=%0d per0=%b per1=%b required 2 1 0", obs_inits, obs_per0, obs_per1);
        end
        n_checks++;
        if (obs_falls_at_init2 !== 2) begin
            n_fail++; $display("FAIL burst_reinit_point: falls=%0d required 2", obs_falls_at_init2);
        end
        n_checks++;
        if (obs_pulses !== 3) begin n_fail++; $display("FAIL burst_pulses: got %0d required 3", obs_pulses); end
        extra = 0;
        prev  = gen_pulse;
        repeat (200) begin
            @(negedge clk);
            if (gen_pulse && !prev) extra++;
            prev = gen_pulse;
        end
        n_checks++;
        if (extra !== 0) begin n_fail++; $display("FAIL burst_quiet: got %0d extra pulses required 0", extra); end
    endtask

    task automatic test_alternate();
        logic [NREQ-1:0] exp_g;
        do_reset();
        req_cnt = '0;
        req_cnt[0*CNT_W +: CNT_W] = CNT_W'(1);
        req_cnt[3*CNT_W +: CNT_W] = CNT_W'(1);
        req = 4'b1001;
        for (int s = 0; s < 4; s++) begin
            exp_g = (s % 2 == 0) ? 4'b0001 : 4'b1000;
            observe(500);
            n_checks++;
            if (obs_timeout || obs_grant !== exp_g || obs_done !== exp_g) begin
                n_fail++; $display("FAIL alt_grant[%0d]: grant=%b done=%b required %b", s, obs_grant, obs_done, exp_g);
            end
            n_checks++;
            if (obs_busy_after !== 1'b0) begin
                n_fail++; $display("FAIL alt_gap[%0d]: busy=%b required 0", s, obs_busy_after);
            end
        end
        req = '0;
    endtask

    task automatic test_timeout();
        do_reset();
        gen_en  = 1'b0;
        req_cnt = '0;
        req_cnt[1*CNT_W +: CNT_W] = CNT_W'(2);
        req = 4'b0010;
        observe(300);
        req = '0;
        n_checks++;
        if (obs_timeout || obs_done !== 4'b0010 || obs_derr !== 1'b1) begin
            n_fail++; $display("FAIL wd_done: done=%b err=%b timeout=%0d required 0010 1 0", obs_done, obs_derr, obs_timeout);
        end
        n_checks++;
        if (obs_run_to_done !== TIMEOUT) begin
            n_fail++; $display("FAIL wd_latency: got %0d required %0d", obs_run_to_done, TIMEOUT);
        end
        n_checks++;
        if (obs_busy_after !== 1'b0) begin n_fail++; $display("FAIL wd_idle: busy=%b required 0", obs_busy_after); end
        gen_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        int              rises;
        int              t;
        int              dones;
        logic            prev;
        logic [2*NREQ+3:0] outs;
        do_reset();
        req_cnt = '0;
        req_cnt[2*CNT_W +: CNT_W] = CNT_W'(5);
        req = 4'b0100;
        rises = 0; t = 0;
        prev = gen_pulse;
        while (rises < 2 && t < 500) begin
            @(negedge clk); t++;
            if (gen_pulse && !prev) rises++;
            prev = gen_pulse;
        end
        n_checks++;
        if (rises !== 2 || grant_o !== 4'b0100) begin
            n_fail++; $display("FAIL mid_progress: rises=%0d grant=%b required 2 0100", rises, grant_o);
        end
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        outs = {grant_o, done_o, done_err_o, busy_o, gen_init_o, gen_per_o};
        n_checks++;
        if (outs !== '0) begin n_fail++; $display("FAIL mid_cleared: got %b required 0", outs); end
        rst   = 1'b0;
        dones = 0;
        repeat (100) begin
            @(negedge clk);
            if (done_o != '0) dones++;
        end
        n_checks++;
        if (dones !== 0) begin n_fail++; $display("FAIL mid_no_done: got %0d done cycles required 0", dones); end
        for (int i = 0; i < NREQ; i++) req_cnt[i*CNT_W +: CNT_W] = CNT_W'(1);
        req = '1;
        observe(500);
        req = '0;
        n_checks++;
        if (obs_timeout || obs_grant !== 4'b0001) begin
            n_fail++; $display("FAIL mid_pointer: grant=%b required 0001", obs_grant);
        end
    endtask

    // Reference model: round-robin pick from the pointer, expected burst
    // length max(n,1), two inits for n>1.
    task automatic test_random();
        int              ptr_m;
        int              exp_idx;
        int              exp_n;
        int              j;
        logic [NREQ-1:0] exp_g;
        do_reset();
        ptr_m    = 0;
        scramble = 1'b1;
        for (int s = 0; s < 12; s++) begin
            req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) req_cnt[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 3));
            exp_idx = -1;
            for (int i = 0; i < NREQ; i++) begin
                j = (ptr_m + i) % NREQ;
                if (exp_idx < 0 && req[j]) exp_idx = j;
            end
            exp_n = int'(req_cnt[exp_idx*CNT_W +: CNT_W]);
            if (exp_n == 0) exp_n = 1;
            exp_g = NREQ'(1 << exp_idx);
            ptr_m = (exp_idx + 1) % NREQ;
            observe(800);
            n_checks++;
            if (obs_timeout || obs_grant !== exp_g || obs_done !== exp_g || obs_derr !== 1'b0 || !obs_stable) begin
                n_fail++; $display("FAIL rand_service[%0d]: grant=%b done=%b err=%b stable=%b required %b %b 0 1", s, obs_grant, obs_done, obs_derr, obs_stable, exp_g, exp_g);
            end
            n_checks++;
            if (obs_pulses !== exp_n || obs_inits !== ((exp_n > 1) ? 2 : 1)) begin
                n_fail++; $display("FAIL rand_pulses[%0d]: pulses=%0d inits=%0d required %0d %0d", s, obs_pulses, obs_inits, exp_n, (exp_n > 1) ? 2 : 1);
            end
            n_checks++;
            if (obs_busy_after !== 1'b0) begin n_fail++; $display("FAIL rand_gap[%0d]: busy=%b required 0", s, obs_busy_after); end
        end
        scramble = 1'b0;
        req      = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_alternate();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
